// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry-adder operand assembler.
//   - default operand width / chunk width / settle window
//   - FSM state encoding
//   - ceil_div() used to derive the number of input beats per frame
package rca_pkg;

   localparam int RCA_WIDTH  = 51;
   localparam int RCA_CHUNK  = 17;
   localparam int RCA_SETTLE = 2;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } rca_state_e;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/rca_operand_assembler_if.sv
// Stream/bus bundle between the operand assembler, its upstream chunk
// source, the external combinational adder and the result consumer.
//   slave  : view taken by rca_operand_assembler
//   master : view taken by the surrounding logic (source, adder, sink)
// Optional macro RCA_ASM_ABORT_EN adds the i_abort signal.
interface rca_operand_assembler_if
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_WIDTH,
   parameter int CHUNK = RCA_CHUNK
);
   logic             i_in_valid;
   logic             o_in_ready;
   logic [CHUNK-1:0] i_chunk1;
   logic [CHUNK-1:0] i_chunk2;
   logic [WIDTH-1:0] o_add_term1;
   logic [WIDTH-1:0] o_add_term2;
   logic [WIDTH:0]   i_adder_result;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [WIDTH:0]   o_result;
`ifdef RCA_ASM_ABORT_EN
   logic             i_abort;
`endif

   modport slave (
      input  i_in_valid, i_chunk1, i_chunk2, i_adder_result, i_out_ready,
`ifdef RCA_ASM_ABORT_EN
      input  i_abort,
`endif
      output o_in_ready, o_add_term1, o_add_term2, o_out_valid, o_result
   );

   modport master (
      output i_in_valid, i_chunk1, i_chunk2, i_adder_result, i_out_ready,
`ifdef RCA_ASM_ABORT_EN
      output i_abort,
`endif
      input  o_in_ready, o_add_term1, o_add_term2, o_out_valid, o_result
   );

endinterface

// File: rtl/rca_chunk_shreg.sv
// One operand register filled chunk by chunk, LSB first.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (register clears to 0)
//   i_wr_en        : write chunk at i_beat_idx this cycle
//   i_beat_idx     : beat number k, chunk lands on bits [k*CHUNK +: CHUNK]
//   i_chunk        : chunk data
//   o_word         : assembled operand
// Chunk bits that would land at or above WIDTH are dropped; untouched
// bits keep their previous value.
module rca_chunk_shreg
   import rca_pkg::*;
#(
   parameter int WIDTH = RCA_WIDTH,
   parameter int CHUNK = RCA_CHUNK,
   parameter int BW    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [BW-1:0]    i_beat_idx,
   input  logic [CHUNK-1:0] i_chunk,
   output logic [WIDTH-1:0] o_word
);

   // Per-bit select keeps every index in range, so the truncated last
   // beat needs no special case.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_word <= '0;
      end else if (i_wr_en) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (i_beat_idx == BW'(i / CHUNK))
               o_word[i] <= i_chunk[i % CHUNK];
         end
      end
   end

endmodule

// File: rtl/rca_operand_assembler.sv
// Operand assembler feeding an external WIDTH-bit ripple-carry adder.
// Collects both addends as CHUNK-bit beats, holds them on o_add_term1/2
// for SETTLE cycles, captures the WIDTH+1-bit sum and offers it downstream.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : input chunk stream, adder operands/result, output stream
// Optional macro RCA_ASM_ABORT_EN: adds bus.i_abort, which drops a partial
// frame (FILL) or a pending capture (SETTLE) without touching the operands.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_FILL   | accepting chunk pairs, beat_cnt = next beat index
// ST_SETTLE | operands stable, settle_cnt counts down to capture
// ST_HOLD   | result valid, waiting for downstream ready
module rca_operand_assembler
   import rca_pkg::*;
#(
   parameter int WIDTH  = RCA_WIDTH,
   parameter int CHUNK  = RCA_CHUNK,
   parameter int SETTLE = RCA_SETTLE
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   rca_operand_assembler_if.slave  bus
);

   localparam int BEATS = ceil_div(WIDTH, CHUNK);
   localparam int BW    = (BEATS  > 1) ? $clog2(BEATS)  : 1;
   localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   rca_state_e      state;
   logic [BW-1:0]   beat_cnt;
   logic [SW-1:0]   settle_cnt;
   logic            abort;
   logic            beat_wr;

`ifdef RCA_ASM_ABORT_EN
   assign abort = bus.i_abort;
`else
   assign abort = 1'b0;
`endif

   // o_in_ready is only high in ST_FILL; abort suppresses the write.
   assign beat_wr = bus.i_in_valid & bus.o_in_ready & ~abort;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= ST_FILL;
         beat_cnt        <= '0;
         settle_cnt      <= '0;
         bus.o_in_ready  <= 1'b1;
         bus.o_out_valid <= 1'b0;
         bus.o_result    <= '0;
      end else begin
         case (state)
            ST_FILL: begin
               if (abort) begin
                  beat_cnt   <= '0;
                  settle_cnt <= '0;
               end else if (beat_wr) begin
                  if (beat_cnt == BW'(BEATS - 1)) begin
                     state          <= ST_SETTLE;
                     beat_cnt       <= '0;
                     settle_cnt     <= SW'(SETTLE - 1);
                     bus.o_in_ready <= 1'b0;
                  end else begin
                     beat_cnt <= beat_cnt + BW'(1);
                  end
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  state          <= ST_FILL;
                  beat_cnt       <= '0;
                  settle_cnt     <= '0;
                  bus.o_in_ready <= 1'b1;
               end else if (settle_cnt == '0) begin
                  state           <= ST_HOLD;
                  bus.o_result    <= bus.i_adder_result;
                  bus.o_out_valid <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - SW'(1);
               end
            end
            ST_HOLD: begin
               if (bus.i_out_ready) begin
                  state           <= ST_FILL;
                  bus.o_out_valid <= 1'b0;
                  bus.o_in_ready  <= 1'b1;
               end
            end
            default: begin
               state           <= ST_FILL;
               beat_cnt        <= '0;
               settle_cnt      <= '0;
               bus.o_in_ready  <= 1'b1;
               bus.o_out_valid <= 1'b0;
            end
         endcase
      end
   end

   rca_chunk_shreg #(.WIDTH(WIDTH), .CHUNK(CHUNK), .BW(BW)) u_term1 (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_en    (beat_wr),
      .i_beat_idx (beat_cnt),
      .i_chunk    (bus.i_chunk1),
      .o_word     (bus.o_add_term1)
   );

   rca_chunk_shreg #(.WIDTH(WIDTH), .CHUNK(CHUNK), .BW(BW)) u_term2 (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_wr_en    (beat_wr),
      .i_beat_idx (beat_cnt),
      .i_chunk    (bus.i_chunk2),
      .o_word     (bus.o_add_term2)
   );

endmodule

// File: doc/rca_operand_assembler.md
Name: rca_operand_assembler

Overview:
- Upstream feeder for the 51-bit ripple-carry adder.
- Accepts both addend operands as narrow chunks over a valid/ready stream and assembles them LSB-first into full-width registers.
- Drives the registered operands to the combinational adder, waits a settle window, then captures the WIDTH+1-bit sum.
- Presents the sum on a valid/ready output stream.

Parameters:
- WIDTH, 51, operand width; result is WIDTH+1 bits.
- CHUNK, 17, bits per operand accepted per input beat.
- SETTLE, 2, cycles between operand-complete and result capture; minimum 1.
- Derived localparam BEATS = ceil(WIDTH/CHUNK), default 3.

Ports:
- i_clk  input  1  single clock, rising edge.
- i_rst_n  input  1  reset, asynchronous assert, active-low.
- i_in_valid  input  1  chunk pair valid.
- o_in_ready  output  1  block can accept a chunk pair.
- i_chunk1  input  CHUNK  next chunk of addend 1.
- i_chunk2  input  CHUNK  next chunk of addend 2.
- o_add_term1  output  WIDTH  registered addend 1 to the adder.
- o_add_term2  output  WIDTH  registered addend 2 to the adder.
- i_adder_result  input  WIDTH+1  combinational sum from the adder.
- o_out_valid  output  1  result valid.
- i_out_ready  input  1  downstream accepts the result.
- o_result  output  WIDTH+1  captured sum, bit WIDTH is carry-out.

Behaviour:
- Reset (i_rst_n low, asynchronous): state=FILL, beat count=0, operand regs=0, o_result=0, o_out_valid=0, o_in_ready=1.

States:
- FILL: o_in_ready=1. On an input handshake (valid&ready), chunk k is written to bits [k*CHUNK +: CHUNK] of both operand regs.
  - Bits at or above WIDTH in the final beat are discarded.
  - Count increments.
  - On the beat where count=BEATS-1, go to SETTLE, reset the settle counter, and clear count to 0.
- SETTLE: o_in_ready=0. Counts SETTLE cycles; operands are stable throughout.
  - In the final settle cycle, o_result <= i_adder_result and go to HOLD.
- HOLD: o_in_ready=0, o_out_valid=1, o_result stable.
  - On i_out_ready, o_out_valid drops next cycle and the state returns to FILL.

Timing and stream rules:
- Minimum latency from the last input handshake to o_out_valid: SETTLE+1 cycles.
- Throughput: one result per BEATS+SETTLE+1 cycles with downstream always ready.
- Chunk data is ignored when valid&ready is false. i_in_valid while in SETTLE/HOLD is stalled, not dropped.
- Backpressure: o_result and o_out_valid hold indefinitely while i_out_ready is low.
- o_add_term1/2 are updated only on FILL handshakes. Partially filled upper bits keep stale values until overwritten; the next result is unaffected, because every bit is rewritten before SETTLE.
- Arithmetic is performed entirely by the adder. The block never modifies i_adder_result.
- Reset mid-operation: a partial frame is lost, no output is produced, and the next beat after release is beat 0.

Optional Feature:
- Macro RCA_ASM_ABORT_EN.
- Defined: adds input port i_abort (1 bit). When high in FILL or SETTLE, count and settle counter clear next cycle, state goes to FILL, and operand regs keep their values. In HOLD it has no effect.
  - When high in the same cycle as an input handshake, abort wins and the chunk is discarded.
- Undefined: port absent; behaviour as above.

Decomposition:
- Shared package rca_pkg holds:
  - state enum {FILL, SETTLE, HOLD}
  - default WIDTH/CHUNK constants
  - a ceil-div function for BEATS
- Sub-module rca_chunk_shreg (one operand's chunk-insert register with beat index) is natural; instantiate it twice.
- The adder stays outside this block; it is connected at the parent level.

Test Plan:
- Three beats of chunk1=17'h1FFFF each and chunk2=1, then 0, then 0, with the adder attached: o_result=52'h8_0000_0000_0000 (all-ones + 1, carry-out set), o_out_valid rises 3 cycles after the last beat.
- Back-to-back frames with i_out_ready=1 (5+7, then 0+0): results 12 then 0 in order; o_in_ready low exactly SETTLE+1 cycles per frame.
- i_out_ready low for 10 cycles in HOLD while i_in_valid stays high: o_result stable, no chunk accepted; first chunk is accepted the cycle after FILL is re-entered.
- i_rst_n pulsed low asynchronously after beat 1 of 3: all outputs are reset values immediately; the next frame 3+4 yields 7.
- CHUNK=16 build (BEATS=4), last-beat chunk1=16'hFFFF: only bits [50:48] are kept; operand 1 = 51'h7_0000_0000_0000 when the earlier beats are 0.
- RCA_ASM_ABORT_EN: i_abort asserted together with beat 2, then a fresh frame 1+1: result 2, and no output is produced for the aborted frame.
